snn_inference_scheduler: RTL and testbench

Round-robin job scheduler that shares one neuromorphic inference engine between two requesters (requester 0: CPU path, requester 1: DMA/stream path). It accepts 8-byte input vectors through a valid/ready handshake, issues each vector to the engine as a one-cycle input pulse, and waits for the engine's output strobe or a timeout. It then returns the 8-byte result to the requester that owns the job. The scheduler sits between the requesters and the engine's input_data/input_valid and output_data/output_valid ports, and it guarantees at most one job in flight.

---
 rtl/snn_inference_scheduler.sv | 168 ++++++++++++++++
 tb/tb_snn_inference_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/snn_inference_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : snn_inference_scheduler
//  Description : Round-robin scheduler sharing one neuromorphic inference
//                engine between two requesters (0: CPU, 1: DMA/stream).
//                At most one job is in flight; each job is issued as a
//                one-cycle pulse and completes on the engine strobe or on a
//                timeout, after which the result returns to its owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_inference_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [63:0] req_data0,
    input  logic [63:0] req_data1,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_timeout,
    output logic [63:0] nm_input_data,
    output logic        nm_input_valid,
    input  logic [63:0] nm_output_data,
    input  logic        nm_output_valid,
    output logic        busy,
    output logic        grant_owner,
    output logic [15:0] jobs_done,
    output logic [15:0] timeouts
);

    localparam logic [1:0]  C_IDLE      = 2'd0;
    localparam logic [1:0]  C_ISSUE     = 2'd1;
    localparam logic [1:0]  C_WAIT      = 2'd2;
    localparam logic [1:0]  C_RESP      = 2'd3;
    localparam logic [15:0] C_WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] C_SAT       = 16'hFFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_rr_prio;
    logic [15:0] r_wait_cnt;
    logic        w_winner;
    logic        w_accept;
    logic        w_rsp_fire;
    logic        w_wait_last;

    logic [1:0]  r_rsp_valid;
    logic [63:0] r_rsp_data;
    logic        r_rsp_timeout;
    logic [63:0] r_nm_input_data;
    logic        r_nm_input_valid;
    logic        r_busy;
    logic        r_grant_owner;
    logic [15:0] r_jobs_done;
    logic [15:0] r_timeouts;

    assign w_accept    = (r_state == C_IDLE) && (req_valid != 2'b00);
    assign w_rsp_fire  = (r_state == C_RESP) && rsp_ready[r_grant_owner];
    assign w_wait_last = (r_wait_cnt == C_WAIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an engine strobe and the timeout both leave WAIT
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE:  if (w_accept) w_next_state = C_ISSUE;
            C_ISSUE: w_next_state = C_WAIT;
            C_WAIT:  if (nm_output_valid || w_wait_last) w_next_state = C_RESP;
            C_RESP:  if (w_rsp_fire) w_next_state = C_IDLE;
            default: w_next_state = C_IDLE;
        endcase
    end

    // Arbitration and request accept: a lone requester always wins,
    // contention is resolved by the round-robin priority bit
    always_comb begin
        w_winner  = 1'b0;
        req_ready = 2'b00;
        case (req_valid)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = r_rr_prio;
            default: w_winner = 1'b0;
        endcase
        if (w_accept) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    // Job datapath, response registers and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_prio        <= 1'b0;
            r_wait_cnt       <= 16'd0;
            r_rsp_valid      <= 2'b00;
            r_rsp_data       <= 64'd0;
            r_rsp_timeout    <= 1'b0;
            r_nm_input_data  <= 64'd0;
            r_nm_input_valid <= 1'b0;
            r_busy           <= 1'b0;
            r_grant_owner    <= 1'b0;
            r_jobs_done      <= 16'd0;
            r_timeouts       <= 16'd0;
        end else begin
            r_nm_input_valid <= 1'b0;
            r_busy           <= (w_next_state != C_IDLE);

            if (w_accept) begin
                r_nm_input_data  <= w_winner ? req_data1 : req_data0;
                r_grant_owner    <= w_winner;
                r_rr_prio        <= ~w_winner;
                r_nm_input_valid <= 1'b1;
            end

            if (r_state == C_ISSUE) begin
                r_wait_cnt <= 16'd0;
            end else if (r_state == C_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end

            // Strobes outside WAIT are stale and dropped
            if (r_state == C_WAIT) begin
                if (nm_output_valid) begin
                    r_rsp_data    <= nm_output_data;
                    r_rsp_timeout <= 1'b0;
                    r_rsp_valid   <= r_grant_owner ? 2'b10 : 2'b01;
                    if (r_jobs_done != C_SAT) begin
                        r_jobs_done <= r_jobs_done + 16'd1;
                    end
                end else if (w_wait_last) begin
                    r_rsp_data    <= 64'd0;
                    r_rsp_timeout <= 1'b1;
                    r_rsp_valid   <= r_grant_owner ? 2'b10 : 2'b01;
                    if (r_timeouts != C_SAT) begin
                        r_timeouts <= r_timeouts + 16'd1;
                    end
                end
            end

            if (w_rsp_fire) begin
                r_rsp_valid <= 2'b00;
            end
        end
    end

    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign rsp_timeout    = r_rsp_timeout;
    assign nm_input_data  = r_nm_input_data;
    assign nm_input_valid = r_nm_input_valid;
    assign busy           = r_busy;
    assign grant_owner    = r_grant_owner;
    assign jobs_done      = r_jobs_done;
    assign timeouts       = r_timeouts;

endmodule
`default_nettype wire

// File: tb/tb_snn_inference_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_snn_inference_scheduler
//  Description : Self-checking bench for snn_inference_scheduler. Directed
//                scenarios followed by random traffic, all compared against
//                a job-timeline reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_inference_scheduler;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [63:0] req_data0 = 64'd0;
    logic [63:0] req_data1 = 64'd0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [63:0] rsp_data;
    logic        rsp_timeout;
    logic [63:0] nm_input_data;
    logic        nm_input_valid;
    logic [63:0] nm_output_data = 64'd0;
    logic        nm_output_valid = 1'b0;
    logic        busy;
    logic        grant_owner;
    logic [15:0] jobs_done;
    logic [15:0] timeouts;

    always #5 clk = ~clk;

    snn_inference_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data0      (req_data0),
        .req_data1      (req_data1),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_timeout    (rsp_timeout),
        .nm_input_data  (nm_input_data),
        .nm_input_valid (nm_input_valid),
        .nm_output_data (nm_output_data),
        .nm_output_valid(nm_output_valid),
        .busy           (busy),
        .grant_owner    (grant_owner),
        .jobs_done      (jobs_done),
        .timeouts       (timeouts)
    );

    // Reference model: a job is either in flight (age counts cycles since
    // acceptance, 1 = issue cycle) or waiting for its response to drain.
    bit          m_active;
    bit          m_resp;
    int          m_age;
    bit          m_owner;
    bit          m_prio;
    logic [63:0] m_in;
    logic [63:0] m_rdata;
    bit          m_to;
    int          m_done;
    int          m_tos;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_resp = 0; m_age = 0; m_owner = 0; m_prio = 0;
        m_in = 64'd0; m_rdata = 64'd0; m_to = 0; m_done = 0; m_tos = 0;
    endtask

    function automatic bit pick(input logic [1:0] rv, input bit prio);
        return (rv == 2'b11) ? prio : rv[1];
    endfunction

    function automatic logic [1:0] exp_ready();
        if (m_active || m_resp || req_valid == 2'b00) return 2'b00;
        return pick(req_valid, m_prio) ? 2'b10 : 2'b01;
    endfunction

    // Advance the model across one rising edge using the applied inputs
    task automatic model_step();
        bit w;
        if (rst) begin
            model_reset();
        end else if (m_active) begin
            if (m_age >= 2) begin
                if (nm_output_valid) begin
                    m_active = 0; m_resp = 1; m_rdata = nm_output_data; m_to = 0;
                    if (m_done < 65535) m_done++;
                end else if (m_age - 2 == TO - 1) begin
                    m_active = 0; m_resp = 1; m_rdata = 64'd0; m_to = 1;
                    if (m_tos < 65535) m_tos++;
                end
            end
            m_age++;
        end else if (m_resp) begin
            if (rsp_ready[m_owner]) m_resp = 0;
        end else if (req_valid != 2'b00) begin
            w = pick(req_valid, m_prio);
            m_owner = w; m_prio = !w; m_in = w ? req_data1 : req_data0;
            m_active = 1; m_age = 1;
        end
    endtask

    task automatic check_outputs(input logic was_rst);
        check_val("busy", busy, m_active || m_resp);
        check_val("nm_input_valid", nm_input_valid, m_active && m_age == 1);
        check_val("nm_input_data", nm_input_data, m_in);
        check_val("rsp_valid", rsp_valid, m_resp ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
        if (m_resp || was_rst) begin
            check_val("rsp_data", rsp_data, m_rdata);
            check_val("rsp_timeout", rsp_timeout, m_to);
        end
        check_val("grant_owner", grant_owner, m_owner);
        check_val("jobs_done", jobs_done, 16'(m_done));
        check_val("timeouts", timeouts, 16'(m_tos));
    endtask

    task automatic cycle(input logic r, input logic [1:0] rv, input logic [1:0] rr,
                         input logic ov, input logic [63:0] od,
                         input logic [63:0] d0, input logic [63:0] d1);
        @(negedge clk);
        rst = r; req_valid = rv; rsp_ready = rr;
        nm_output_valid = ov; nm_output_data = od;
        req_data0 = d0; req_data1 = d1;
        #1;
        check_val("req_ready", req_ready, exp_ready());
        model_step();
        @(posedge clk);
        #1;
        check_outputs(r);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_cycle(input logic [1:0] rr, input logic ov);
        cycle(1'b0, 2'b00, rr, ov, rnd64(), rnd64(), rnd64());
    endtask

    task automatic do_reset();
        cycle(1'b1, 2'b00, 2'b00, 1'b0, 64'd0, 64'd0, 64'd0);
        cycle(1'b1, 2'b11, 2'b11, 1'b1, rnd64(), rnd64(), rnd64());
    endtask

    initial begin
        model_reset();

        // Reset state
        do_reset();
        check_val("reset_jobs_done", jobs_done, 16'd0);

        // Single job: engine answers three cycles after the issue pulse
        cycle(1'b0, 2'b01, 2'b00, 1'b0, 64'd0, 64'h0102030405060708, rnd64());
        check_val("single_issue_data", nm_input_data, 64'h0102030405060708);
        idle_cycle(2'b00, 1'b0);
        idle_cycle(2'b00, 1'b0);
        idle_cycle(2'b00, 1'b0);
        cycle(1'b0, 2'b00, 2'b00, 1'b1, 64'hFF00FF00FF00FF00, 64'd0, 64'd0);
        check_val("single_rsp_data", rsp_data, 64'hFF00FF00FF00FF00);
        check_val("single_rsp_valid", rsp_valid, 2'b01);
        idle_cycle(2'b01, 1'b0);
        check_val("single_jobs_done", jobs_done, 16'd1);

        // Contention with an immediately responding engine
        do_reset();
        for (int i = 0; i < 24; i++)
            cycle(1'b0, 2'b11, 2'b11, 1'b1, rnd64(), rnd64(), rnd64());

        // Timeout with a late strobe during RESP
        do_reset();
        cycle(1'b0, 2'b01, 2'b00, 1'b0, 64'd0, rnd64(), rnd64());
        for (int i = 0; i < 1 + TO; i++) idle_cycle(2'b00, 1'b0);
        check_val("to_flag", rsp_timeout, 1'b1);
        check_val("to_count", timeouts, 16'd1);
        idle_cycle(2'b00, 1'b1);
        idle_cycle(2'b01, 1'b0);
        check_val("to_late_jobs_done", jobs_done, 16'd0);

        // Strobe on the final wait cycle wins over the timeout
        do_reset();
        cycle(1'b0, 2'b10, 2'b00, 1'b0, 64'd0, rnd64(), rnd64());
        for (int i = 0; i < TO; i++) idle_cycle(2'b00, 1'b0);
        cycle(1'b0, 2'b00, 2'b00, 1'b1, 64'h1122334455667788, 64'd0, 64'd0);
        check_val("tie_timeout", rsp_timeout, 1'b0);
        check_val("tie_jobs_done", jobs_done, 16'd1);
        idle_cycle(2'b10, 1'b0);

        // Backpressure with stray strobes and a pending requester 1
        do_reset();
        cycle(1'b0, 2'b01, 2'b00, 1'b0, 64'd0, rnd64(), rnd64());
        idle_cycle(2'b00, 1'b0);
        cycle(1'b0, 2'b00, 2'b00, 1'b1, 64'hA5A5_5A5A_DEAD_BEEF, 64'd0, 64'd0);
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 2'b10, 2'b10, i[0], rnd64(), rnd64(), rnd64());
        check_val("bp_rsp_data", rsp_data, 64'hA5A5_5A5A_DEAD_BEEF);
        cycle(1'b0, 2'b10, 2'b01, 1'b0, 64'd0, rnd64(), rnd64());
        cycle(1'b0, 2'b10, 2'b00, 1'b0, 64'd0, rnd64(), rnd64());
        check_val("bp_next_owner", grant_owner, 1'b1);

        // Reset mid-job, then let the dropped job's window pass
        do_reset();
        cycle(1'b0, 2'b01, 2'b00, 1'b0, 64'd0, rnd64(), rnd64());
        idle_cycle(2'b00, 1'b0);
        idle_cycle(2'b00, 1'b0);
        cycle(1'b1, 2'b00, 2'b00, 1'b0, 64'd0, 64'd0, 64'd0);
        check_val("mid_rst_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) idle_cycle(2'b11, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  2'($urandom),
                  ($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom),
                  ($urandom_range(0, 3) == 0),
                  rnd64(), rnd64(), rnd64());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
